iob_picorv32_bus_arb: RTL and testbench

- Two-master, one-slave arbiter for IOb native buses. It merges the PicoRV32 wrapper's instruction bus and data bus onto a single shared memory port, for example a single-port boot RAM or an external-memory bridge.
- Grants one transaction at a time and tracks the single outstanding read so rvalid returns to the correct master.
- Sits between the CPU wrapper and the shared memory.

---
 rtl/iob_picorv32_bus_arb.sv | 132 +++++++++++++
 tb/tb_iob_picorv32_bus_arb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/iob_picorv32_bus_arb.sv
// Two-master, one-slave IOb arbiter: merges the PicoRV32 data bus (m0) and instruction bus (m1) onto one memory port.
// Optional build macro IOB_PICORV32_ARB_RR_EN selects round-robin arbitration; by default m0 has fixed priority.
module iob_picorv32_bus_arb #(
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  localparam int WSTRB_W = DATA_W / 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cke_i,
  input  logic               m0_avalid_i,
  input  logic [ADDR_W-1:0]  m0_addr_i,
  input  logic [DATA_W-1:0]  m0_wdata_i,
  input  logic [WSTRB_W-1:0] m0_wstrb_i,
  output logic [DATA_W-1:0]  m0_rdata_o,
  output logic               m0_rvalid_o,
  output logic               m0_ready_o,
  input  logic               m1_avalid_i,
  input  logic [ADDR_W-1:0]  m1_addr_i,
  input  logic [DATA_W-1:0]  m1_wdata_i,
  input  logic [WSTRB_W-1:0] m1_wstrb_i,
  output logic [DATA_W-1:0]  m1_rdata_o,
  output logic               m1_rvalid_o,
  output logic               m1_ready_o,
  output logic               s_avalid_o,
  output logic [ADDR_W-1:0]  s_addr_o,
  output logic [DATA_W-1:0]  s_wdata_o,
  output logic [WSTRB_W-1:0] s_wstrb_o,
  input  logic [DATA_W-1:0]  s_rdata_i,
  input  logic               s_rvalid_i,
  input  logic               s_ready_i
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   grant;
  logic   accept;

  logic               sel_avalid;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [WSTRB_W-1:0] sel_wstrb;

`ifdef IOB_PICORV32_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    if (m0_avalid_i && m1_avalid_i) grant = ~last_grant_q;
    else                            grant = m1_avalid_i;
  end
`else
  always_comb begin
    grant = m1_avalid_i & ~m0_avalid_i;
  end
`endif

  assign sel_avalid = grant ? m1_avalid_i : m0_avalid_i;
  assign sel_addr   = grant ? m1_addr_i   : m0_addr_i;
  assign sel_wdata  = grant ? m1_wdata_i  : m0_wdata_i;
  assign sel_wstrb  = grant ? m1_wstrb_i  : m0_wstrb_i;

  // Read data is broadcast; only rvalid is steered, so reads see no added latency.
  assign m0_rdata_o = s_rdata_i;
  assign m1_rdata_o = s_rdata_i;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    accept      = 1'b0;
    s_avalid_o  = 1'b0;
    s_addr_o    = '0;
    s_wdata_o   = '0;
    s_wstrb_o   = '0;
    m0_ready_o  = 1'b0;
    m1_ready_o  = 1'b0;
    m0_rvalid_o = 1'b0;
    m1_rvalid_o = 1'b0;
`ifdef IOB_PICORV32_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (sel_avalid) begin
          s_avalid_o = cke_i;
          s_addr_o   = sel_addr;
          s_wdata_o  = sel_wdata;
          s_wstrb_o  = sel_wstrb;
        end
        accept     = sel_avalid & cke_i & s_ready_i;
        m0_ready_o = accept & ~grant;
        m1_ready_o = accept & grant;
        if (accept) begin
`ifdef IOB_PICORV32_ARB_RR_EN
          last_grant_d = grant;
`endif
          // Writes complete on acceptance; only reads hold the bus until rvalid.
          if (sel_wstrb == '0) begin
            owner_d = grant;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (s_rvalid_i && cke_i) begin
          m0_rvalid_o = ~owner_q;
          m1_rvalid_o = owner_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
`ifdef IOB_PICORV32_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else if (cke_i) begin
      state_q <= state_d;
      owner_q <= owner_d;
`ifdef IOB_PICORV32_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule

// File: tb/tb_iob_picorv32_bus_arb.sv
// Self-checking bench for iob_picorv32_bus_arb: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_iob_picorv32_bus_arb;

`ifdef IOB_PICORV32_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cke;
  logic        av [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [3:0]  ws [2];
  logic [31:0] s_rdata;
  logic        s_rvalid, s_ready;

  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic        m0_rvalid, m1_rvalid, m0_ready, m1_ready, s_avalid;
  logic [3:0]  s_wstrb;

  iob_picorv32_bus_arb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .cke_i(cke),
    .m0_avalid_i(av[0]), .m0_addr_i(ad[0]), .m0_wdata_i(wd[0]), .m0_wstrb_i(ws[0]),
    .m0_rdata_o(m0_rdata), .m0_rvalid_o(m0_rvalid), .m0_ready_o(m0_ready),
    .m1_avalid_i(av[1]), .m1_addr_i(ad[1]), .m1_wdata_i(wd[1]), .m1_wstrb_i(ws[1]),
    .m1_rdata_o(m1_rdata), .m1_rvalid_o(m1_rvalid), .m1_ready_o(m1_ready),
    .s_avalid_o(s_avalid), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
    .s_rdata_i(s_rdata), .s_rvalid_i(s_rvalid), .s_ready_i(s_ready)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: which master (if any) has a read outstanding, and who won last.
  int pend  = -1;
  bit lastg = 1'b1;

  int          rdy_cnt [2];
  int          rv_cnt  [2];
  logic [31:0] rv_data [2];
  logic [31:0] acc_addr;
  int          gq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int m = 0; m < 2; m++) begin
      rdy_cnt[m] = 0;
      rv_cnt[m]  = 0;
      rv_data[m] = '0;
    end
    acc_addr = '0;
    gq.delete();
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic cyc();
    logic        e_sav, acc;
    logic [31:0] e_sad, e_swd;
    logic [3:0]  e_sws;
    logic        e_rdy [2];
    logic        e_rv  [2];
    int          g;
    @(negedge clk);
    e_sav = 0; e_sad = 0; e_swd = 0; e_sws = 0; acc = 0; g = 0;
    e_rdy[0] = 0; e_rdy[1] = 0; e_rv[0] = 0; e_rv[1] = 0;
    if (pend < 0) begin
      if (av[0] || av[1]) begin
        if (av[0] && av[1]) g = RR ? int'(!lastg) : 0;
        else                g = av[1] ? 1 : 0;
        e_sav = cke;
        e_sad = ad[g]; e_swd = wd[g]; e_sws = ws[g];
        acc = cke && s_ready;
        e_rdy[g] = acc;
      end
    end else if (cke && s_rvalid) begin
      e_rv[pend] = 1'b1;
    end
    chk("s_avalid",  32'(s_avalid),  32'(e_sav));
    chk("s_addr",    s_addr,         e_sad);
    chk("s_wdata",   s_wdata,        e_swd);
    chk("s_wstrb",   32'(s_wstrb),   32'(e_sws));
    chk("m0_ready",  32'(m0_ready),  32'(e_rdy[0]));
    chk("m1_ready",  32'(m1_ready),  32'(e_rdy[1]));
    chk("m0_rvalid", 32'(m0_rvalid), 32'(e_rv[0]));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(e_rv[1]));
    chk("m0_rdata",  m0_rdata,       s_rdata);
    chk("m1_rdata",  m1_rdata,       s_rdata);
    if (m0_ready) begin rdy_cnt[0]++; gq.push_back(0); acc_addr = s_addr; end
    if (m1_ready) begin rdy_cnt[1]++; gq.push_back(1); acc_addr = s_addr; end
    if (m0_rvalid) begin rv_cnt[0]++; rv_data[0] = m0_rdata; end
    if (m1_rvalid) begin rv_cnt[1]++; rv_data[1] = m1_rdata; end
    if (rst) begin
      pend = -1; lastg = 1'b1;
    end else if (cke) begin
      if (pend >= 0 && s_rvalid) pend = -1;
      else if (pend < 0 && acc) begin
        lastg = g[0];
        if (ws[g] == 4'h0) pend = g;
      end
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) if (e_rdy[m]) av[m] = 1'b0;
  endtask

  task automatic req(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    av[m] = 1'b1; ad[m] = a; wd[m] = d; ws[m] = s;
  endtask

  initial begin
    rst = 1; cke = 1; s_rdata = 0; s_rvalid = 0; s_ready = 0;
    for (int m = 0; m < 2; m++) begin av[m] = 0; ad[m] = 0; wd[m] = 0; ws[m] = 0; end
    clr();
    #1;

    // Reset, idle, stray rvalid in IDLE.
    cyc(); cyc();
    rst = 0;
    cyc();
    s_rvalid = 1; cyc();
    s_rvalid = 0; cyc();
    chk("idle_rvalid_cnt", 32'(rv_cnt[0] + rv_cnt[1]), 32'd0);

    // m1 read of 0x100, data two cycles after acceptance.
    clr();
    req(1, 32'h100, 32'h0, 4'h0); s_ready = 1;
    cyc();
    s_ready = 0; cyc();
    s_rvalid = 1; s_rdata = 32'hDEADBEEF; cyc();
    s_rvalid = 0; s_rdata = 0; cyc();
    chk("m1rd_ready_cnt",  32'(rdy_cnt[1]), 32'd1);
    chk("m1rd_addr",       acc_addr,        32'h100);
    chk("m1rd_rvalid_cnt", 32'(rv_cnt[1]),  32'd1);
    chk("m1rd_rdata",      rv_data[1],      32'hDEADBEEF);
    chk("m1rd_m0_rvalid",  32'(rv_cnt[0]),  32'd0);

    // Back-to-back m0 writes.
    clr();
    s_ready = 1;
    req(0, 32'h40, 32'h12345678, 4'hF); cyc();
    chk("wr1_addr", acc_addr, 32'h40);
    req(0, 32'h44, 32'h9ABCDEF0, 4'h3); cyc();
    chk("wr2_addr", acc_addr, 32'h44);
    chk("wr_ready_cnt", 32'(rdy_cnt[0]), 32'd2);
    cyc();

    // Contended reads, both masters re-requesting immediately.
    rst = 1; cyc(); rst = 0;
    clr();
    s_ready = 1;
    req(0, 32'h200, 0, 4'h0); req(1, 32'h300, 0, 4'h0);
    for (int i = 0; i < 40 && gq.size() < 4; i++) begin
      s_rvalid = (pend >= 0);
      s_rdata  = $urandom;
      cyc();
      if (!av[0]) req(0, 32'h200 + 32'(i), 0, 4'h0);
      if (!av[1]) req(1, 32'h300 + 32'(i), 0, 4'h0);
    end
    chk("cont_grants", 32'(gq.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      int want;
      want = RR ? (k % 2) : 0;
      chk($sformatf("cont_order%0d", k), (k < gq.size()) ? 32'(gq[k]) : 32'hFFFF_FFFF, 32'(want));
    end
    av[0] = 0; av[1] = 0;
    s_rvalid = 1; cyc(); s_rvalid = 0; cyc();

    // Reset while a read is outstanding.
    clr();
    req(0, 32'h500, 0, 4'h0); s_ready = 1; cyc();
    rst = 1; cyc(); rst = 0;
    s_rvalid = 1; s_rdata = 32'h5555AAAA; cyc();
    s_rvalid = 0; cyc();
    chk("rstrd_dropped", 32'(rv_cnt[0] + rv_cnt[1]), 32'd0);
    req(0, 32'h504, 0, 4'h0); cyc();
    s_rvalid = 1; s_rdata = 32'hCAFE0001; cyc();
    s_rvalid = 0; cyc();
    chk("rstrd_new_rvalid", 32'(rv_cnt[0]), 32'd1);
    chk("rstrd_new_rdata",  rv_data[0],     32'hCAFE0001);

    // Clock enable low while m1's read is outstanding.
    clr();
    req(1, 32'h600, 0, 4'h0); s_ready = 1; cyc();
    req(0, 32'h700, 0, 4'h0);
    cke = 0; cyc(); cyc(); cyc();
    chk("cke_no_accept", 32'(rdy_cnt[0]), 32'd0);
    cke = 1; s_rvalid = 1; s_rdata = 32'h0BADF00D; cyc();
    s_rvalid = 0; cyc();
    chk("cke_m1_rvalid", 32'(rv_cnt[1]), 32'd1);
    chk("cke_m0_rvalid", 32'(rv_cnt[0]), 32'd0);
    chk("cke_rdata",     rv_data[1],     32'h0BADF00D);
    s_rvalid = 1; cyc(); s_rvalid = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!av[m] && ($urandom % 2 == 0)) begin
          req(m, $urandom, $urandom, ($urandom % 2 == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
        end
      end
      s_ready  = ($urandom % 4) != 0;
      s_rvalid = ($urandom % 3) == 0;
      s_rdata  = $urandom;
      cke      = ($urandom % 8) != 0;
      rst      = ($urandom % 64) == 0;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
